// File: rtl/cave_ddr_pkg.sv
// cave_ddr_pkg
//   Shared types and constants for the ROM download / DDR arbitration slice:
//   arbiter state encoding, DDR bus widths and the download line-address helper.
package cave_ddr_pkg;

   localparam int unsigned DDR_DATA_W  = 64;
   localparam int unsigned DDR_BE_W    = 8;
   localparam int unsigned DDR_BURST_W = 8;
   localparam int unsigned DL_ADDR_W   = 25;
   localparam int unsigned DL_WORD_W   = 16;
   localparam int unsigned LINE_IDX_W  = 22;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ_CMD,
      READ_DATA
   } arb_state_t;

   // DDR byte address of a 64-bit download line; wraps modulo 2^32 and is
   // always 8-byte aligned regardless of the low bits of the base.
   function automatic logic [31:0] line_byte_addr(input logic [31:0] base,
                                                  input logic [LINE_IDX_W-1:0] line);
      return (base + {7'b000_0000, line, 3'b000}) & 32'hFFFF_FFF8;
   endfunction

endpackage

// File: rtl/rom_download_arbiter_dl_packer.sv
// dl_packer
//   Packs 16-bit download words into 64-bit DDR lines and hands complete (or
//   partial) lines to a one-entry write-pending register.
// Ports:
//   clk_sys, RESET          clock, async active-high reset
//   dl_cs, dl_wr            download active / word strobe
//   dl_addr, dl_dout        download byte address (bit 0 ignored) / word
//   dl_wait                 stall: a flush is needed but the pending slot is busy
//   pend_clear              arbiter has issued the pending line
//   pend_valid              pending line present
//   pend_addr/din/be        pending line DDR address, data, byte enables
module dl_packer
   import cave_ddr_pkg::*;
#(
   parameter logic [31:0] DL_BASE = 32'h3000_0000
) (
   input  logic                    clk_sys,
   input  logic                    RESET,
   input  logic                    dl_cs,
   input  logic                    dl_wr,
   input  logic [DL_ADDR_W-1:0]    dl_addr,
   input  logic [DL_WORD_W-1:0]    dl_dout,
   output logic                    dl_wait,
   input  logic                    pend_clear,
   output logic                    pend_valid,
   output logic [31:0]             pend_addr,
   output logic [DDR_DATA_W-1:0]   pend_din,
   output logic [DDR_BE_W-1:0]     pend_be
);

   logic                    cs_d;
   logic [LINE_IDX_W-1:0]   line_idx;
   logic [DDR_DATA_W-1:0]   line_data;
   logic [DDR_BE_W-1:0]     line_be;

   logic                    cs_rise;
   logic [1:0]              lane;
   logic                    line_open;
   logic                    flush_old;
   logic                    flush_new;
   logic                    flush_idle;
   logic                    accept;
   logic                    load_old;
   logic [DDR_DATA_W-1:0]   merged_data;
   logic [DDR_BE_W-1:0]     merged_be;
   logic                    unused_addr_lsb;

   always_comb begin
      unused_addr_lsb = dl_addr[0];
      cs_rise    = dl_cs & ~cs_d;
      lane       = dl_addr[2:1];
      line_open  = |line_be;
      flush_old  = dl_cs & dl_wr & ~cs_rise & line_open & (dl_addr[24:3] != line_idx);
      flush_new  = dl_cs & dl_wr & (lane == 2'd3);
      flush_idle = ~dl_cs & line_open;
      // A word that both leaves the open line and completes its own line needs
      // two flushes: stall one cycle while the old line takes the slot.
      dl_wait    = (flush_old | flush_new | flush_idle) &
                   (pend_valid | (flush_old & flush_new));
      accept     = dl_cs & dl_wr & ~dl_wait;
      load_old   = (flush_old | flush_idle) & ~pend_valid;

      if (cs_rise | flush_old) begin
         merged_data = '0;
         merged_be   = '0;
      end else begin
         merged_data = line_data;
         merged_be   = line_be;
      end
      merged_data[{lane, 4'b0000} +: DL_WORD_W] = dl_dout;
      merged_be = merged_be | (8'b0000_0011 << {lane, 1'b0});
   end

   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         cs_d       <= 1'b0;
         line_idx   <= '0;
         line_data  <= '0;
         line_be    <= '0;
         pend_valid <= 1'b0;
         pend_addr  <= '0;
         pend_din   <= '0;
         pend_be    <= '0;
      end else begin
         cs_d <= dl_cs;

         if (pend_clear)
            pend_valid <= 1'b0;

         if (load_old) begin
            pend_valid <= 1'b1;
            pend_addr  <= line_byte_addr(DL_BASE, line_idx);
            pend_din   <= line_data;
            pend_be    <= line_be;
         end

         if (accept) begin
            line_idx <= dl_addr[24:3];
            if (flush_new) begin
               pend_valid <= 1'b1;
               pend_addr  <= line_byte_addr(DL_BASE, dl_addr[24:3]);
               pend_din   <= merged_data;
               pend_be    <= merged_be;
               line_data  <= '0;
               line_be    <= '0;
            end else begin
               line_data <= merged_data;
               line_be   <= merged_be;
            end
         end else if (cs_rise | load_old) begin
            line_data <= '0;
            line_be   <= '0;
            if (cs_rise)
               line_idx <= '0;
         end
      end
   end

endmodule

// File: rtl/rom_download_arbiter.sv
// rom_download_arbiter
//   Shares one DDR port between the ROM download path (packed 64-bit line
//   writes) and ROM read bursts. Writes win over reads; a read burst in
//   flight is never preempted.
// Ports:
//   clk_sys, RESET                  clock, async active-high reset
//   dl_cs/dl_wr/dl_addr/dl_dout     download word interface
//   dl_wait                         download stall
//   rd_req/rd_addr/rd_burst         read request (held until rd_ack)
//   rd_ack                          one-cycle request accept
//   rd_valid/rd_data                read beats, one cycle after DDR
//   ddr_rd/ddr_we/ddr_addr/ddr_din/ddr_be/ddr_burstcnt   DDR command
//   ddr_busy                        DDR wait request
//   ddr_dout/ddr_dout_ready         DDR read data
module rom_download_arbiter
   import cave_ddr_pkg::*;
#(
   parameter logic [31:0] DL_BASE = 32'h3000_0000
) (
   input  logic                    clk_sys,
   input  logic                    RESET,
   input  logic                    dl_cs,
   input  logic                    dl_wr,
   input  logic [DL_ADDR_W-1:0]    dl_addr,
   input  logic [DL_WORD_W-1:0]    dl_dout,
   output logic                    dl_wait,
   input  logic                    rd_req,
   input  logic [31:0]             rd_addr,
   input  logic [DDR_BURST_W-1:0]  rd_burst,
   output logic                    rd_ack,
   output logic                    rd_valid,
   output logic [DDR_DATA_W-1:0]   rd_data,
   output logic                    ddr_rd,
   output logic                    ddr_we,
   output logic [31:0]             ddr_addr,
   output logic [DDR_DATA_W-1:0]   ddr_din,
   output logic [DDR_BE_W-1:0]     ddr_be,
   output logic [DDR_BURST_W-1:0]  ddr_burstcnt,
   input  logic                    ddr_busy,
   input  logic [DDR_DATA_W-1:0]   ddr_dout,
   input  logic                    ddr_dout_ready
);

   arb_state_t                state;
   logic [DDR_BURST_W-1:0]    beats_left;
   logic [DDR_BURST_W-1:0]    rd_burst_eff;
   logic                      pend_clear;
   logic                      pend_valid;
   logic [31:0]               pend_addr;
   logic [DDR_DATA_W-1:0]     pend_din;
   logic [DDR_BE_W-1:0]       pend_be;
   logic                      beat_in;
   logic                      unused_rd_lsb;

   dl_packer #(
      .DL_BASE (DL_BASE)
   ) u_packer (
      .clk_sys    (clk_sys),
      .RESET      (RESET),
      .dl_cs      (dl_cs),
      .dl_wr      (dl_wr),
      .dl_addr    (dl_addr),
      .dl_dout    (dl_dout),
      .dl_wait    (dl_wait),
      .pend_clear (pend_clear),
      .pend_valid (pend_valid),
      .pend_addr  (pend_addr),
      .pend_din   (pend_din),
      .pend_be    (pend_be)
   );

   always_comb begin
      unused_rd_lsb = ^rd_addr[2:0];
      rd_burst_eff  = (rd_burst == '0) ? 8'd1 : rd_burst;
      pend_clear    = (state == WRITE) & ~ddr_busy;
      beat_in       = (state == READ_DATA) & ddr_dout_ready;
   end

   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         state        <= IDLE;
         beats_left   <= '0;
         ddr_rd       <= 1'b0;
         ddr_we       <= 1'b0;
         ddr_addr     <= '0;
         ddr_din      <= '0;
         ddr_be       <= '0;
         ddr_burstcnt <= '0;
         rd_ack       <= 1'b0;
         rd_valid     <= 1'b0;
         rd_data      <= '0;
      end else begin
         rd_ack   <= 1'b0;
         rd_valid <= beat_in;
         if (beat_in)
            rd_data <= ddr_dout;

         case (state)
            IDLE: begin
               if (pend_valid) begin
                  state        <= WRITE;
                  ddr_we       <= 1'b1;
                  ddr_addr     <= pend_addr;
                  ddr_din      <= pend_din;
                  ddr_be       <= pend_be;
                  ddr_burstcnt <= 8'd1;
               end else if (rd_req) begin
                  state        <= READ_CMD;
                  rd_ack       <= 1'b1;
                  ddr_rd       <= 1'b1;
                  ddr_addr     <= {rd_addr[31:3], 3'b000};
                  ddr_burstcnt <= rd_burst_eff;
                  beats_left   <= rd_burst_eff;
               end
            end
            WRITE: begin
               if (!ddr_busy) begin
                  ddr_we <= 1'b0;
                  state  <= IDLE;
               end
            end
            READ_CMD: begin
               if (!ddr_busy) begin
                  ddr_rd <= 1'b0;
                  state  <= READ_DATA;
               end
            end
            READ_DATA: begin
               if (ddr_dout_ready) begin
                  beats_left <= beats_left - 8'd1;
                  if (beats_left == 8'd1)
                     state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_download_arbiter.sv
// tb_rom_download_arbiter
//   Directed bench: drives download words, read requests and DDR responses,
//   records DDR commands and read beats, and compares against hand-computed
//   expectations.
module tb_rom_download_arbiter;

   logic        clk_sys = 1'b0;
   logic        RESET;
   logic        dl_cs, dl_wr;
   logic [24:0] dl_addr;
   logic [15:0] dl_dout;
   logic        dl_wait;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic [7:0]  rd_burst;
   logic        rd_ack, rd_valid;
   logic [63:0] rd_data;
   logic        ddr_rd, ddr_we;
   logic [31:0] ddr_addr;
   logic [63:0] ddr_din;
   logic [7:0]  ddr_be, ddr_burstcnt;
   logic        ddr_busy;
   logic [63:0] ddr_dout;
   logic        ddr_dout_ready;

   always #5 clk_sys = ~clk_sys;

   rom_download_arbiter #(
      .DL_BASE (32'h3000_0000)
   ) dut (
      .clk_sys        (clk_sys),
      .RESET          (RESET),
      .dl_cs          (dl_cs),
      .dl_wr          (dl_wr),
      .dl_addr        (dl_addr),
      .dl_dout        (dl_dout),
      .dl_wait        (dl_wait),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_burst       (rd_burst),
      .rd_ack         (rd_ack),
      .rd_valid       (rd_valid),
      .rd_data        (rd_data),
      .ddr_rd         (ddr_rd),
      .ddr_we         (ddr_we),
      .ddr_addr       (ddr_addr),
      .ddr_din        (ddr_din),
      .ddr_be         (ddr_be),
      .ddr_burstcnt   (ddr_burstcnt),
      .ddr_busy       (ddr_busy),
      .ddr_dout       (ddr_dout),
      .ddr_dout_ready (ddr_dout_ready)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // ---------------- monitor ----------------
   typedef struct packed {
      logic [31:0] addr;
      logic [63:0] din;
      logic [7:0]  be;
      logic [7:0]  bc;
   } cmd_t;

   cmd_t        wq[$];
   cmd_t        rq[$];
   logic [63:0] vdata[$];
   int          vcyc[$];
   int          dcyc[$];
   string       ev = "";
   int          cyc = 0;
   int          ack_cnt = 0;
   int          both_cnt = 0;
   int          we_busy_cnt = 0;

   always @(posedge clk_sys) cyc <= cyc + 1;

   always @(negedge clk_sys) begin
      if (!RESET) begin
         if (ddr_we && ddr_rd) both_cnt++;
         if (ddr_we && ddr_busy) we_busy_cnt++;
         if (ddr_we && !ddr_busy) begin
            wq.push_back({ddr_addr, ddr_din, ddr_be, ddr_burstcnt});
            ev = {ev, "W"};
         end
         if (ddr_rd && !ddr_busy) begin
            rq.push_back({ddr_addr, 64'h0, 8'h0, ddr_burstcnt});
            ev = {ev, "R"};
         end
         if (rd_ack) ack_cnt++;
         if (rd_valid) begin
            vdata.push_back(rd_data);
            vcyc.push_back(cyc);
         end
         if (ddr_dout_ready) dcyc.push_back(cyc);
      end
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic dl_word(input logic [24:0] a, input logic [15:0] d);
      dl_addr = a;
      dl_dout = d;
      dl_wr   = 1'b1;
      #1;
      for (int i = 0; i < 50 && dl_wait; i++) step();
      if (dl_wait) check_eq("dl_word_stall", dl_wait, 1'b0);
      step();
      dl_wr = 1'b0;
   endtask

   task automatic read_req(input logic [31:0] a, input logic [7:0] b);
      rd_addr  = a;
      rd_burst = b;
      rd_req   = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_sys);
         if (rd_ack) break;
      end
      check_eq("rd_ack_seen", rd_ack, 1'b1);
      step();
      rd_req = 1'b0;
   endtask

   task automatic beat(input logic [63:0] d);
      ddr_dout_ready = 1'b1;
      ddr_dout       = d;
      step();
      ddr_dout_ready = 1'b0;
   endtask

   function automatic cmd_t pop_wr();
      cmd_t c;
      c = '0;
      if (wq.size() > 0) c = wq.pop_front();
      return c;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      cmd_t c;
      int   ack0, web0;

      RESET = 1'b1;
      dl_cs = 0; dl_wr = 0; dl_addr = '0; dl_dout = '0;
      rd_req = 0; rd_addr = '0; rd_burst = '0;
      ddr_busy = 0; ddr_dout = '0; ddr_dout_ready = 0;
      repeat (3) step();

      check_eq("rst_we_rd", {ddr_we, ddr_rd, rd_ack, rd_valid, dl_wait}, 5'b0);
      check_eq("rst_addr", ddr_addr, 32'h0);
      check_eq("rst_din", ddr_din, 64'h0);
      check_eq("rst_be_bc", {ddr_be, ddr_burstcnt}, 16'h0);
      check_eq("rst_rdata", rd_data, 64'h0);

      RESET = 1'b0;
      step();

      // full line of four words
      dl_cs = 1'b1;
      step();
      dl_word(25'h0, 16'h1111);
      dl_word(25'h2, 16'h2222);
      dl_word(25'h4, 16'h3333);
      dl_word(25'h6, 16'h4444);
      repeat (5) step();
      check_eq("t1_nwr", wq.size(), 1);
      c = pop_wr();
      check_eq("t1_addr", c.addr, 32'h3000_0000);
      check_eq("t1_din", c.din, 64'h4444_3333_2222_1111);
      check_eq("t1_be", c.be, 8'hFF);
      check_eq("t1_bc", c.bc, 8'd1);
      dl_cs = 1'b0;
      repeat (4) step();
      check_eq("t1_no_extra", wq.size(), 0);

      // partial line flushed by dl_cs falling
      dl_cs = 1'b1;
      step();
      dl_word(25'h2, 16'hABCD);
      dl_cs = 1'b0;
      repeat (6) step();
      check_eq("t2_nwr", wq.size(), 1);
      c = pop_wr();
      check_eq("t2_addr", c.addr, 32'h3000_0000);
      check_eq("t2_be", c.be, 8'h0C);
      check_eq("t2_din", c.din, 64'h0000_0000_ABCD_0000);

      // DDR busy during WRITE while a second line completes
      dl_cs = 1'b1;
      step();
      ddr_busy = 1'b1;
      web0 = we_busy_cnt;
      dl_word(25'h08, 16'hA001);
      dl_word(25'h0A, 16'hA002);
      dl_word(25'h0C, 16'hA003);
      dl_word(25'h0E, 16'hA004);
      dl_word(25'h10, 16'hB001);
      dl_word(25'h12, 16'hB002);
      dl_word(25'h14, 16'hB003);
      dl_addr = 25'h16;
      dl_dout = 16'hB004;
      dl_wr   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_sys);
         check_eq($sformatf("t3_wait%0d", i), dl_wait, 1'b1);
         step();
      end
      check_eq("t3_wr_held", wq.size(), 0);
      ddr_busy = 1'b0;
      for (int i = 0; i < 20 && dl_wait; i++) step();
      check_eq("t3_wait_drop", dl_wait, 1'b0);
      step();
      dl_wr = 1'b0;
      repeat (6) step();
      check_eq("t3_busy_cycles", we_busy_cnt - web0, 5);
      check_eq("t3_nwr", wq.size(), 2);
      c = pop_wr();
      check_eq("t3_a_addr", c.addr, 32'h3000_0008);
      check_eq("t3_a_din", c.din, 64'hA004_A003_A002_A001);
      c = pop_wr();
      check_eq("t3_b_addr", c.addr, 32'h3000_0010);
      check_eq("t3_b_din", c.din, 64'hB004_B003_B002_B001);
      check_eq("t3_b_be", c.be, 8'hFF);

      // write pending and read request in the same cycle
      ev = "";
      rq.delete(); vdata.delete(); vcyc.delete(); dcyc.delete();
      ack0 = ack_cnt;
      dl_word(25'h1E, 16'h5555);
      read_req(32'h0000_0100, 8'd4);
      for (int b = 0; b < 4; b++) begin
         beat(64'hD0D0_0000_0000_0000 | 64'(b));
         if (b == 1) step();
      end
      repeat (3) step();
      check_eq("t4_order", (ev == "WR"), 1'b1);
      c = pop_wr();
      check_eq("t4_wr_addr", c.addr, 32'h3000_0018);
      check_eq("t4_wr_din", c.din, 64'h5555_0000_0000_0000);
      check_eq("t4_wr_be", c.be, 8'hC0);
      check_eq("t4_nrd", rq.size(), 1);
      if (rq.size() > 0) begin
         check_eq("t4_rd_addr", rq[0].addr, 32'h0000_0100);
         check_eq("t4_rd_bc", rq[0].bc, 8'd4);
      end
      check_eq("t4_acks", ack_cnt - ack0, 1);
      check_eq("t4_nbeats", vdata.size(), 4);
      for (int i = 0; i < 4 && i < vdata.size() && i < dcyc.size(); i++) begin
         check_eq($sformatf("t4_data%0d", i), vdata[i], 64'hD0D0_0000_0000_0000 | 64'(i));
         check_eq($sformatf("t4_lat%0d", i), vcyc[i], dcyc[i] + 1);
      end

      // zero burst length
      rq.delete(); vdata.delete();
      read_req(32'h0000_0208, 8'd0);
      beat(64'hBEEF_0001);
      beat(64'h0000_0BAD);
      repeat (3) step();
      check_eq("t5_nrd", rq.size(), 1);
      if (rq.size() > 0) begin
         check_eq("t5_bc", rq[0].bc, 8'd1);
         check_eq("t5_addr", rq[0].addr, 32'h0000_0208);
      end
      check_eq("t5_nbeats", vdata.size(), 1);
      if (vdata.size() > 0) check_eq("t5_data", vdata[0], 64'hBEEF_0001);

      // reset in the middle of a burst with an open download line
      rq.delete(); vdata.delete();
      dl_word(25'h40, 16'h7777);
      read_req(32'h0000_0400, 8'd4);
      beat(64'h1);
      beat(64'h2);
      RESET = 1'b1;
      #1;
      check_eq("t6_rst_flags", {ddr_we, ddr_rd, rd_ack, rd_valid, dl_wait}, 5'b0);
      check_eq("t6_rst_addr", ddr_addr, 32'h0);
      check_eq("t6_rst_be_bc", {ddr_be, ddr_burstcnt}, 16'h0);
      check_eq("t6_rst_din", ddr_din, 64'h0);
      check_eq("t6_rst_rdata", rd_data, 64'h0);
      dl_cs = 1'b0;
      ack0 = ack_cnt;
      repeat (2) step();
      RESET = 1'b0;
      step();
      beat(64'h0000_0F00);
      repeat (6) step();
      check_eq("t6_nbeats", vdata.size(), 1);
      check_eq("t6_no_wr", wq.size(), 0);
      check_eq("t6_no_ack", ack_cnt - ack0, 0);
      check_eq("t6_idle_flags", {ddr_we, ddr_rd, rd_valid}, 3'b0);

      check_eq("excl_rd_we", both_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rom_download_arbiter.md
ROM_DOWNLOAD_ARBITER -- requirements
Module: rom_download_arbiter

Interface
REQ-001 SHALL have parameter DL_BASE, default 32'h3000_0000: DDR byte base address of the downloaded ROM image.
REQ-002 SHALL have ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- dl_cs  in  1  download active.
- dl_wr  in  1  download word strobe.
- dl_addr  in  25  download byte address, bit 0 ignored.
- dl_dout  in  16  download word.
- dl_wait  out  1  download stall.
- rd_req  in  1  ROM read request, held until rd_ack.
- rd_addr  in  32  read byte address, bits [2:0] ignored.
- rd_burst  in  8  read burst length in 64-bit beats.
- rd_ack  out  1  one-cycle request accept.
- rd_valid  out  1  read beat valid.
- rd_data  out  64  read beat data.
- ddr_rd  out  1  DDR read command.
- ddr_we  out  1  DDR write command.
- ddr_addr  out  32  DDR byte address, bits [2:0] always 0.
- ddr_din  out  64  DDR write data.
- ddr_be  out  8  DDR byte enables.
- ddr_burstcnt  out  8  DDR burst count.
- ddr_busy  in  1  DDR wait request.
- ddr_dout  in  64  DDR read data.
- ddr_dout_ready  in  1  DDR read beat valid.

Function
REQ-003 Packer SHALL place a word accepted on dl_cs & dl_wr into ddr_din lane n = dl_addr[2:1] (bits 16n+15:16n) and set ddr_be bits 2n+1:2n.
REQ-004 Line address SHALL be DL_BASE + {dl_addr[24:3], 3'b000}, modulo 2^32.
REQ-005 Packer SHALL flush the line: when lane 3 is written; before accepting a word whose dl_addr[24:3] differs from the open line; and on the cycle after dl_cs falls if any byte enable is set.
REQ-006 A flushed line SHALL go to a one-entry write-pending register; dl_wait SHALL be high whenever a flush is required while that register is occupied, and dl_wr SHALL be ignored while dl_wait is high.
REQ-007 Rising edge of dl_cs SHALL clear the open line and all its byte enables; dl_wr with dl_cs low SHALL be ignored.
REQ-008 Arbiter states SHALL be IDLE, WRITE, READ_CMD and READ_DATA.
REQ-009 In IDLE, a pending write SHALL go to WRITE; otherwise rd_req SHALL pulse rd_ack, latch address/burst, and go to READ_CMD. Write has priority over read.
REQ-010 WRITE SHALL hold ddr_we=1, ddr_burstcnt=1 with stable addr/din/be until a cycle with ddr_busy=0, then free the pending register and return to IDLE.
REQ-011 READ_CMD SHALL hold ddr_rd=1 with the latched address and burst until a cycle with ddr_busy=0, then go to READ_DATA.
REQ-012 READ_DATA SHALL count ddr_dout_ready beats and return to IDLE on the last beat; it SHALL NOT be preempted by a pending write.
REQ-013 rd_burst=0 SHALL be treated as 1.
REQ-014 rd_valid/rd_data SHALL be ddr_dout_ready/ddr_dout registered, giving one cycle of latency; ddr_dout_ready outside READ_DATA SHALL be ignored.
REQ-015 ddr_rd and ddr_we SHALL never be high in the same cycle.

Reset
REQ-016 While RESET is high, the state SHALL be IDLE, and all of the following SHALL be 0: ddr_rd, ddr_we, rd_ack, rd_valid, dl_wait, ddr_be, ddr_burstcnt, ddr_addr, ddr_din, rd_data.
REQ-017 RESET mid-operation SHALL discard any open line, pending write and outstanding burst count, with no completion pulse afterwards.

Structure
REQ-018 Package cave_ddr_pkg SHALL hold the arbiter state enum, DDR_DATA_W=64, DDR_BE_W=8 and DDR_BURST_W=8.
REQ-019 The word packer (REQ-003 to REQ-007) SHALL be the sub-module dl_packer; arbitration stays in the top.

Verification
REQ-020 Writes 16'h1111/2222/3333/4444 at dl_addr 0,2,4,6 -> one ddr_we at 32'h3000_0000 with din 64'h4444_3333_2222_1111 and be 8'hFF.
REQ-021 Write 16'hABCD at dl_addr 2, then dl_cs falls -> ddr_we with be 8'h0C and din[31:16]=16'hABCD.
REQ-022 ddr_busy held high 5 cycles during WRITE while a second line completes -> dl_wait high until the first write is accepted, and no word is lost.
REQ-023 rd_req with rd_addr 32'h100 and burst 4, with a write pending in the same cycle -> write issued first, then ddr_rd burstcnt 4, then four rd_valid pulses each one cycle after ddr_dout_ready.
REQ-024 rd_burst=0 -> ddr_burstcnt=1 and a single beat back to IDLE.
REQ-025 RESET asserted after beat 2 of 4 -> all outputs 0 immediately; after release, stray ddr_dout_ready gives no rd_valid.
